// File: rtl/dark_acq_pkg.sv
// Shared state encoding, default timing constants and the registered control-output payload
// for the dark-count acquisition sequencer.
package dark_acq_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;

  localparam int unsigned TICK_DIV_DEF   = 50_000_000;
  localparam int unsigned SETTLE_CYC_DEF = 4;

  typedef struct packed {
    logic cnt_en;
    logic cnt_clr;
    logic cnt_latch;
    logic busy;
    logic done;
    logic aborted;
  } ctl_out_t;

endpackage

// File: rtl/dark_acq_sequencer_if.sv
// Control/status bundle between the start/abort front panel and the acquisition sequencer.
interface dark_acq_sequencer_if #(
  parameter int unsigned GATE_W = 8,
  parameter int unsigned RUN_W  = 16
);
  logic              start;
  logic              abort;
  logic              cont;
  logic [GATE_W-1:0] gate_len;
  logic              cnt_en;
  logic              cnt_clr;
  logic              cnt_latch;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [RUN_W-1:0]  run_cnt;

  modport master (
    output start, abort, cont, gate_len,
    input  cnt_en, cnt_clr, cnt_latch, busy, done, aborted, run_cnt
  );

  modport slave (
    input  start, abort, cont, gate_len,
    output cnt_en, cnt_clr, cnt_latch, busy, done, aborted, run_cnt
  );
endinterface

// File: rtl/acq_tick_gen.sv
// Gate-tick prescaler: registered 1-cycle tick every TICK_DIV clocks, phase-aligned so the
// first tick lands TICK_DIV cycles after a synchronous restart (TICK_DIV >= 2).
module acq_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);
  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else begin
      // Registered tick, so decode one count early.
      tick_d = (cnt_q == CNT_W'(TICK_DIV - 2));
      if (cnt_q == CNT_W'(TICK_DIV - 1)) cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_o <= tick_d;
    end
  end
endmodule

// File: rtl/dark_acq_sequencer.sv
// Clear / gate / settle / latch sequencer for the MPPC BCD dark counter.
// Optional build macro DAS_CONT_MODE_EN: re-arm directly from LATCH while cont is high.
module dark_acq_sequencer
  import dark_acq_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned GATE_W     = 8,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned RUN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dark_acq_sequencer_if.slave   das
);
  localparam int unsigned SET_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [GATE_W-1:0]  gate_len_q, gate_len_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  ctl_out_t           out_q, out_d;
  logic               sync1_q, sync2_q, sync3_q, start_pulse_q;
  logic               restart_c, tick;

  // Start button: 2-FF synchronizer plus registered rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      sync1_q       <= das.start;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      start_pulse_q <= sync2_q & ~sync3_q;
    end
  end

  acq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart_c),
    .tick_o    (tick)
  );

  always_comb begin
    state_d    = state_q;
    gate_len_d = gate_len_q;
    gate_cnt_d = gate_cnt_q;
    settle_d   = settle_q;
    run_cnt_d  = run_cnt_q;
    restart_c  = 1'b0;
    out_d      = '0;

    case (state_q)
      S_IDLE:   if (start_pulse_q && !das.abort) state_d = S_CLEAR;
      S_CLEAR: begin
        restart_c  = 1'b1;
        gate_cnt_d = '0;
        state_d    = S_GATE;
      end
      S_GATE: begin
        if (tick) begin
          if (gate_cnt_q == GATE_W'(gate_len_q - GATE_W'(1))) state_d = S_SETTLE;
          else gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = S_LATCH;
        else settle_d = settle_q + SET_W'(1);
      end
      S_LATCH: begin
`ifdef DAS_CONT_MODE_EN
        state_d = das.cont ? S_CLEAR : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides every transition out of a busy state.
    if (das.abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      out_d.aborted = 1'b1;
    end

    if (state_d != S_SETTLE) settle_d = '0;
    if ((state_d == S_CLEAR) && (state_q != S_CLEAR))
      gate_len_d = (das.gate_len == '0) ? GATE_W'(1) : das.gate_len;
    if (state_d == S_LATCH) run_cnt_d = run_cnt_q + RUN_W'(1);

    out_d.cnt_clr   = (state_d == S_CLEAR);
    out_d.cnt_en    = (state_d == S_GATE);
    out_d.cnt_latch = (state_d == S_LATCH);
    out_d.done      = (state_d == S_LATCH);
    out_d.busy      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gate_len_q <= '0;
      gate_cnt_q <= '0;
      settle_q   <= '0;
      run_cnt_q  <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      gate_len_q <= gate_len_d;
      gate_cnt_q <= gate_cnt_d;
      settle_q   <= settle_d;
      run_cnt_q  <= run_cnt_d;
      out_q      <= out_d;
    end
  end

`ifndef DAS_CONT_MODE_EN
  logic unused_cont;
  assign unused_cont = das.cont;
`endif

  assign das.cnt_en    = out_q.cnt_en;
  assign das.cnt_clr   = out_q.cnt_clr;
  assign das.cnt_latch = out_q.cnt_latch;
  assign das.busy      = out_q.busy;
  assign das.done      = out_q.done;
  assign das.aborted   = out_q.aborted;
  assign das.run_cnt   = run_cnt_q;
endmodule

// File: tb/tb_dark_acq_sequencer.sv
// Scenario bench for dark_acq_sequencer with a run scoreboard (TICK_DIV=4, SETTLE_CYC=4).
module tb_dark_acq_sequencer;
  localparam int TICK_DIV = 4;
  localparam int SETTLE   = 4;

  typedef struct {
    int          en_len;
    int          gap;
    logic [15:0] run;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dark_acq_sequencer_if #(.GATE_W(8), .RUN_W(16)) das ();

  dark_acq_sequencer #(
    .TICK_DIV(TICK_DIV), .GATE_W(8), .SETTLE_CYC(SETTLE), .RUN_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .das (das)
  );

  exp_t exp_q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  int   en_run = 0, last_en_len = 0, since_fall = 0, last_gap = -1;
  int   clr_run = 0, last_clr_len = 0, clr_total = 0;
  int   done_total = 0, aborted_total = 0, busy_falls = 0;
  logic prev_en = 1'b0, prev_clr = 1'b0, prev_busy = 1'b0;

  // Observation side: pulse widths, settle gap and event totals, sampled on the falling edge.
  always @(negedge clk) begin
    if (das.cnt_en === 1'b1) en_run++;
    else if (prev_en) begin last_en_len = en_run; en_run = 0; end
    if (prev_en && das.cnt_en !== 1'b1) since_fall = 0;
    else since_fall++;
    if (das.cnt_latch === 1'b1) last_gap = since_fall;
    if (das.cnt_clr === 1'b1) begin
      clr_run++;
      if (!prev_clr) clr_total++;
    end else if (prev_clr) begin last_clr_len = clr_run; clr_run = 0; end
    if (das.done === 1'b1) done_total++;
    if (das.aborted === 1'b1) aborted_total++;
    if (prev_busy && das.busy !== 1'b1) busy_falls++;
    prev_en   = (das.cnt_en === 1'b1);
    prev_clr  = (das.cnt_clr === 1'b1);
    prev_busy = (das.busy === 1'b1);
  end

  function automatic exp_t mk(int en_len, int gap, int run);
    exp_t e;
    e.en_len = en_len;
    e.gap    = gap;
    e.run    = 16'(run);
    return e;
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (das.done === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_en(input logic lvl, output bit got);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (das.cnt_en === lvl) begin got = 1'b1; break; end
    end
  endtask

  task automatic pulse_start;
    das.start = 1'b0;
    step(4);
    das.start = 1'b1;
    step(6);
    das.start = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = mk(-1, -1, 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    das.start = 1'b0; das.abort = 1'b0; das.cont = 1'b0; das.gate_len = 8'd0;
    step(3);
    chk_cnt++; if (das.cnt_en !== 1'b0) $display("FAIL reset_cnt_en got %b exp 0", das.cnt_en); else pass_cnt++;
    chk_cnt++; if (das.cnt_clr !== 1'b0) $display("FAIL reset_cnt_clr got %b exp 0", das.cnt_clr); else pass_cnt++;
    chk_cnt++; if (das.cnt_latch !== 1'b0) $display("FAIL reset_cnt_latch got %b exp 0", das.cnt_latch); else pass_cnt++;
    chk_cnt++; if (das.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", das.busy); else pass_cnt++;
    chk_cnt++; if (das.done !== 1'b0) $display("FAIL reset_done got %b exp 0", das.done); else pass_cnt++;
    chk_cnt++; if (das.aborted !== 1'b0) $display("FAIL reset_aborted got %b exp 0", das.aborted); else pass_cnt++;
    chk_cnt++; if (das.run_cnt !== 16'd0) $display("FAIL reset_run_cnt got %0d exp 0", das.run_cnt); else pass_cnt++;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_basic;
    bit got; exp_t e;
    das.gate_len = 8'd3;
    exp_q.push_back(mk(3 * TICK_DIV, SETTLE, 1));
    pulse_start();
    wait_done(got);
    chk_cnt++; if (!got) $display("FAIL basic_timeout got no done exp done"); else pass_cnt++;
    pop_exp(e);
    chk_cnt++; if (last_en_len !== e.en_len) $display("FAIL basic_en_len got %0d exp %0d", last_en_len, e.en_len); else pass_cnt++;
    chk_cnt++; if (last_gap !== e.gap) $display("FAIL basic_settle_gap got %0d exp %0d", last_gap, e.gap); else pass_cnt++;
    chk_cnt++; if (das.run_cnt !== e.run) $display("FAIL basic_run_cnt got %0d exp %0d", das.run_cnt, e.run); else pass_cnt++;
    chk_cnt++; if (das.cnt_latch !== 1'b1) $display("FAIL basic_latch_with_done got %b exp 1", das.cnt_latch); else pass_cnt++;
    chk_cnt++; if (last_clr_len !== 1) $display("FAIL basic_clr_len got %0d exp 1", last_clr_len); else pass_cnt++;
    step(1);
    chk_cnt++; if (das.busy !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", das.busy); else pass_cnt++;
    chk_cnt++; if (das.done !== 1'b0) $display("FAIL basic_done_width got %b exp 0", das.done); else pass_cnt++;
  endtask

  task automatic test_gate_zero;
    bit got; exp_t e;
    das.gate_len = 8'd0;
    exp_q.push_back(mk(TICK_DIV, SETTLE, 2));
    pulse_start();
    wait_done(got);
    chk_cnt++; if (!got) $display("FAIL zero_timeout got no done exp done"); else pass_cnt++;
    pop_exp(e);
    chk_cnt++; if (last_en_len !== e.en_len) $display("FAIL zero_en_len got %0d exp %0d", last_en_len, e.en_len); else pass_cnt++;
    chk_cnt++; if (das.run_cnt !== e.run) $display("FAIL zero_run_cnt got %0d exp %0d", das.run_cnt, e.run); else pass_cnt++;
    step(2);
  endtask

  task automatic test_abort;
    bit got; int base_done, base_ab;
    das.gate_len = 8'd5;
    das.start = 1'b0; step(4);
    das.start = 1'b1;
    wait_en(1'b1, got);
    das.start = 1'b0;
    chk_cnt++; if (!got) $display("FAIL abort_gate_timeout got no cnt_en exp cnt_en"); else pass_cnt++;
    base_done = done_total; base_ab = aborted_total;
    step(4);
    das.abort = 1'b1;
    step(1);
    das.abort = 1'b0;
    chk_cnt++; if (das.cnt_en !== 1'b0) $display("FAIL abort_cnt_en got %b exp 0", das.cnt_en); else pass_cnt++;
    chk_cnt++; if (das.aborted !== 1'b1) $display("FAIL abort_pulse got %b exp 1", das.aborted); else pass_cnt++;
    chk_cnt++; if (das.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", das.busy); else pass_cnt++;
    step(40);
    chk_cnt++; if (done_total !== base_done) $display("FAIL abort_no_done got %0d exp %0d", done_total, base_done); else pass_cnt++;
    chk_cnt++; if (aborted_total !== base_ab + 1) $display("FAIL abort_once got %0d exp %0d", aborted_total, base_ab + 1); else pass_cnt++;
    chk_cnt++; if (das.run_cnt !== 16'd2) $display("FAIL abort_run_cnt got %0d exp 2", das.run_cnt); else pass_cnt++;
  endtask

  task automatic test_abort_idle;
    int base_ab, base_clr, busy_seen;
    base_ab = aborted_total; base_clr = clr_total; busy_seen = 0;
    das.abort = 1'b1;
    das.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (das.busy === 1'b1) busy_seen++;
    end
    das.abort = 1'b0;
    das.start = 1'b0;
    step(5);
    chk_cnt++; if (busy_seen !== 0) $display("FAIL idle_abort_busy got %0d exp 0", busy_seen); else pass_cnt++;
    chk_cnt++; if (aborted_total !== base_ab) $display("FAIL idle_abort_pulse got %0d exp %0d", aborted_total, base_ab); else pass_cnt++;
    chk_cnt++; if (clr_total !== base_clr) $display("FAIL idle_abort_start_dropped got %0d exp %0d", clr_total, base_clr); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit got; exp_t e; int base_done;
    das.gate_len = 8'd2;
    base_done = done_total;
    exp_q.push_back(mk(2 * TICK_DIV, SETTLE, 3));
    das.start = 1'b0; step(4);
    das.start = 1'b1;
    wait_en(1'b1, got);
    das.start = 1'b0;
    step(2);
    das.start = 1'b1;
    wait_done(got);
    chk_cnt++; if (!got) $display("FAIL b2b_timeout got no done exp done"); else pass_cnt++;
    pop_exp(e);
    chk_cnt++; if (last_en_len !== e.en_len) $display("FAIL b2b_en_len got %0d exp %0d", last_en_len, e.en_len); else pass_cnt++;
    chk_cnt++; if (das.run_cnt !== e.run) $display("FAIL b2b_run_cnt got %0d exp %0d", das.run_cnt, e.run); else pass_cnt++;
    step(20);
    chk_cnt++; if (done_total !== base_done + 1) $display("FAIL b2b_single_done got %0d exp %0d", done_total, base_done + 1); else pass_cnt++;
    chk_cnt++; if (das.busy !== 1'b0) $display("FAIL b2b_idle got %b exp 0", das.busy); else pass_cnt++;
    exp_q.push_back(mk(2 * TICK_DIV, SETTLE, 4));
    pulse_start();
    wait_done(got);
    chk_cnt++; if (!got) $display("FAIL b2b_run2_timeout got no done exp done"); else pass_cnt++;
    pop_exp(e);
    chk_cnt++; if (das.run_cnt !== e.run) $display("FAIL b2b_run2_cnt got %0d exp %0d", das.run_cnt, e.run); else pass_cnt++;
    step(2);
  endtask

  task automatic test_cont;
    bit got; exp_t e; int base_falls, base_clr;
    das.gate_len = 8'd1;
    das.cont = 1'b1;
    base_falls = busy_falls; base_clr = clr_total;
`ifdef DAS_CONT_MODE_EN
    for (int r = 0; r < 3; r++) exp_q.push_back(mk(TICK_DIV, SETTLE, 5 + r));
    pulse_start();
    for (int r = 0; r < 3; r++) begin
      wait_done(got);
      chk_cnt++; if (!got) $display("FAIL cont_timeout run %0d got no done exp done", r); else pass_cnt++;
      pop_exp(e);
      chk_cnt++; if (das.run_cnt !== e.run) $display("FAIL cont_run_cnt got %0d exp %0d", das.run_cnt, e.run); else pass_cnt++;
      chk_cnt++; if (last_en_len !== e.en_len) $display("FAIL cont_en_len got %0d exp %0d", last_en_len, e.en_len); else pass_cnt++;
      if (r < 2) begin
        step(1);
        chk_cnt++; if (das.cnt_clr !== 1'b1) $display("FAIL cont_rearm_clr got %b exp 1", das.cnt_clr); else pass_cnt++;
      end else begin
        das.cont = 1'b0;
        step(1);
        chk_cnt++; if (das.busy !== 1'b0) $display("FAIL cont_stop_busy got %b exp 0", das.busy); else pass_cnt++;
      end
    end
    chk_cnt++; if (busy_falls !== base_falls + 1) $display("FAIL cont_busy_falls got %0d exp %0d", busy_falls, base_falls + 1); else pass_cnt++;
    chk_cnt++; if (clr_total !== base_clr + 3) $display("FAIL cont_clr_total got %0d exp %0d", clr_total, base_clr + 3); else pass_cnt++;
`else
    exp_q.push_back(mk(TICK_DIV, SETTLE, 5));
    pulse_start();
    wait_done(got);
    chk_cnt++; if (!got) $display("FAIL nocont_timeout got no done exp done"); else pass_cnt++;
    pop_exp(e);
    chk_cnt++; if (das.run_cnt !== e.run) $display("FAIL nocont_run_cnt got %0d exp %0d", das.run_cnt, e.run); else pass_cnt++;
    step(1);
    chk_cnt++; if (das.busy !== 1'b0) $display("FAIL nocont_busy got %b exp 0", das.busy); else pass_cnt++;
    step(20);
    chk_cnt++; if (clr_total !== base_clr + 1) $display("FAIL nocont_clr_total got %0d exp %0d", clr_total, base_clr + 1); else pass_cnt++;
    chk_cnt++; if (busy_falls !== base_falls + 1) $display("FAIL nocont_busy_falls got %0d exp %0d", busy_falls, base_falls + 1); else pass_cnt++;
`endif
    das.cont = 1'b0;
    step(2);
  endtask

  task automatic test_rst_settle;
    bit got; int base_done;
    das.gate_len = 8'd1;
    base_done = done_total;
    das.start = 1'b0; step(4);
    das.start = 1'b1;
    wait_en(1'b1, got);
    chk_cnt++; if (!got) $display("FAIL rst_gate_timeout got no cnt_en exp cnt_en"); else pass_cnt++;
    wait_en(1'b0, got);
    das.start = 1'b0;
    chk_cnt++; if (!got) $display("FAIL rst_settle_timeout got cnt_en stuck exp fall"); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (das.busy !== 1'b0) $display("FAIL rst_async_busy got %b exp 0", das.busy); else pass_cnt++;
    chk_cnt++; if (das.cnt_latch !== 1'b0) $display("FAIL rst_async_latch got %b exp 0", das.cnt_latch); else pass_cnt++;
    chk_cnt++; if (das.cnt_en !== 1'b0) $display("FAIL rst_async_cnt_en got %b exp 0", das.cnt_en); else pass_cnt++;
    chk_cnt++; if (das.run_cnt !== 16'd0) $display("FAIL rst_async_run_cnt got %0d exp 0", das.run_cnt); else pass_cnt++;
    step(1);
    rst = 1'b0;
    step(15);
    chk_cnt++; if (done_total !== base_done) $display("FAIL rst_no_latch got %0d exp %0d", done_total, base_done); else pass_cnt++;
    chk_cnt++; if (das.busy !== 1'b0) $display("FAIL rst_idle got %b exp 0", das.busy); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gate_zero();
    test_abort();
    test_abort_idle();
    test_back_to_back();
    test_cont();
    test_rst_settle();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
